// File: rtl/vga_sram_arbiter.sv
// Time-slotted SRAM arbiter: six CPU write slots and one video read slot per 16-cycle frame,
// with a small in-order FIFO buffering CPU writes between slots.
module vga_sram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        C25M,
  input  logic        RST,
  input  logic        LineStart,
  input  logic [16:0] FetchAddr,
  input  logic        WrReq,
  input  logic [16:0] WrAddr,
  input  logic [15:0] WrData,
  input  logic        WrnUDS,
  input  logic        WrnLDS,
  output logic        WrFull,
  output logic        Overflow,
  output logic [16:0] RA,
  output logic [15:0] RDout,
  output logic        RDoe,
  input  logic [15:0] RDin,
  output logic        nRCSH,
  output logic        nRCSL,
  output logic        nRWE,
  output logic [15:0] VidData,
  output logic        VidValid
);

  localparam logic [3:0] PH_V_ADDR = 4'd12;
  localparam logic [3:0] PH_V_CS1  = 4'd13;
  localparam logic [3:0] PH_V_CS2  = 4'd14;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [3:0]    phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          full_q, overflow_q, overflow_d;
  logic [16:0]   ra_q, ra_d;
  logic [15:0]   rdout_q, rdout_d;
  logic          rdoe_q, rdoe_d;
  logic          ncsh_q, ncsh_d, ncsl_q, ncsl_d, nrwe_q, nrwe_d;
  logic [15:0]   viddata_q, viddata_d;
  logic          vidvalid_q, vidvalid_d;
  logic          wract_q, wract_d;

  // Entry layout: {nUDS, nLDS, addr[16:0], data[15:0]}
  logic [34:0] mem [FIFO_DEPTH];
  logic [34:0] head;
  logic        empty, is_full, push, pop;

  assign head    = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign is_full = (count_q == CW'(FIFO_DEPTH));
  assign pop     = wract_q && phase_q[0] && (phase_q < PH_V_ADDR) && !LineStart;
  assign push    = WrReq && (!is_full || pop);

  always_comb begin
    phase_d    = LineStart ? 4'd0 : phase_q + 4'd1;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (WrReq & ~push);
    ra_d       = ra_q;
    rdout_d    = rdout_q;
    rdoe_d     = rdoe_q;
    ncsh_d     = ncsh_q;
    ncsl_d     = ncsl_q;
    nrwe_d     = nrwe_q;
    viddata_d  = viddata_q;
    vidvalid_d = 1'b0;
    wract_d    = 1'b0;
    if (LineStart) begin
      // Realignment abandons whatever slot is in flight; the FIFO head is kept for retry.
      ncsh_d = 1'b1;
      ncsl_d = 1'b1;
    end else if (phase_q < PH_V_ADDR) begin
      if (!phase_q[0]) begin
        ncsh_d = 1'b1;
        ncsl_d = 1'b1;
        if (!empty) begin
          ra_d    = head[32:16];
          rdout_d = head[15:0];
          nrwe_d  = 1'b0;
          rdoe_d  = 1'b1;
          wract_d = 1'b1;
        end else begin
          nrwe_d = 1'b1;
          rdoe_d = 1'b0;
        end
      end else if (wract_q) begin
        ncsh_d = head[34];
        ncsl_d = head[33];
      end else begin
        ncsh_d = 1'b1;
        ncsl_d = 1'b1;
      end
    end else begin
      case (phase_q)
        PH_V_ADDR: begin
          ra_d   = FetchAddr;
          nrwe_d = 1'b1;
          rdoe_d = 1'b0;
          ncsh_d = 1'b1;
          ncsl_d = 1'b1;
        end
        PH_V_CS1, PH_V_CS2: begin
          ncsh_d = 1'b0;
          ncsl_d = 1'b0;
        end
        default: begin
          ncsh_d     = 1'b1;
          ncsl_d     = 1'b1;
          viddata_d  = RDin;
          vidvalid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge C25M or posedge RST) begin
    if (RST) begin
      phase_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      ra_q       <= '0;
      rdout_q    <= '0;
      rdoe_q     <= 1'b0;
      ncsh_q     <= 1'b1;
      ncsl_q     <= 1'b1;
      nrwe_q     <= 1'b1;
      viddata_q  <= '0;
      vidvalid_q <= 1'b0;
      wract_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      count_q    <= count_d;
      wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      full_q     <= (count_d == CW'(FIFO_DEPTH));
      overflow_q <= overflow_d;
      ra_q       <= ra_d;
      rdout_q    <= rdout_d;
      rdoe_q     <= rdoe_d;
      ncsh_q     <= ncsh_d;
      ncsl_q     <= ncsl_d;
      nrwe_q     <= nrwe_d;
      viddata_q  <= viddata_d;
      vidvalid_q <= vidvalid_d;
      wract_q    <= wract_d;
    end
  end

  always_ff @(posedge C25M) begin
    if (push) mem[wr_ptr_q] <= {WrnUDS, WrnLDS, WrAddr, WrData};
  end

  assign WrFull   = full_q;
  assign Overflow = overflow_q;
  assign RA       = ra_q;
  assign RDout    = rdout_q;
  assign RDoe     = rdoe_q;
  assign nRCSH    = ncsh_q;
  assign nRCSL    = ncsl_q;
  assign nRWE     = nrwe_q;
  assign VidData  = viddata_q;
  assign VidValid = vidvalid_q;

endmodule

// File: doc/vga_sram_arbiter.md
VGA_SRAM_ARBITER -- requirements
Module: vga_sram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, CPU-write FIFO entries (power of two, 2..16).
REQ-002 SHALL have port C25M  in  1  pixel/system clock; all logic on rising edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port LineStart  in  1  one-cycle pulse at horizontal counter wrap; realigns slot phase.
REQ-005 SHALL have port FetchAddr  in  17  video word address for next read slot.
REQ-006 SHALL have port WrReq  in  1  one-cycle pulse; captured CPU write, already synchronized to C25M.
REQ-007 SHALL have ports WrAddr in 17, WrData in 16, WrnUDS in 1, WrnLDS in 1: write address, data, active-low byte strobes, valid with WrReq.
REQ-008 SHALL have port WrFull  out  1  FIFO holds FIFO_DEPTH entries.
REQ-009 SHALL have port Overflow  out  1  sticky; a WrReq was dropped.
REQ-010 SHALL have ports RA out 17, RDout out 16, RDoe out 1, RDin in 16: SRAM address, write data, data-bus drive enable, read data.
REQ-011 SHALL have ports nRCSH, nRCSL, nRWE  out  1 each: SRAM upper/lower chip selects, write enable, active-low, registered.
REQ-012 SHALL have ports VidData out 16, VidValid out 1: fetched video word, one-cycle valid pulse.

Function
REQ-013 SHALL keep 4-bit Phase counter: +1 per cycle, 15 wraps to 0; LineStart high forces Phase=0 next cycle.
REQ-014 SHALL allocate Phase 0-11 to six CPU write slots (even = SETUP, odd = STROBE), Phase 12-15 to video read slot (V_ADDR, V_CS1, V_CS2, V_CAP).
REQ-015 SETUP with FIFO non-empty: RA<=head addr, RDout<=head data, nRWE<=0, RDoe<=1, nRCSH=nRCSL<=1; head not yet removed.
REQ-016 SETUP with FIFO empty: nRWE<=1, RDoe<=0, chip selects <=1; following STROBE idle.
REQ-017 STROBE after active SETUP: nRCSH<=head WrnUDS, nRCSL<=head WrnLDS; head removed this cycle; entry with both strobes high is removed with no chip select asserted.
REQ-018 Next SETUP or V_ADDR SHALL deassert both chip selects (write pulse exactly one cycle).
REQ-019 V_ADDR: RA<=FetchAddr, nRWE<=1, RDoe<=0, chip selects <=1.
REQ-020 V_CS1, V_CS2: nRCSH=nRCSL<=0.
REQ-021 V_CAP: chip selects <=1, VidData<=RDin, VidValid<=1 for exactly this cycle's result (one cycle).
REQ-022 FIFO SHALL be in-order; WrReq pushes when count<FIFO_DEPTH, or count=FIFO_DEPTH with same-cycle removal.
REQ-023 WrReq when full without same-cycle removal: entry dropped, Overflow<=1 until reset; FIFO contents unchanged.
REQ-024 WrFull SHALL equal (count==FIFO_DEPTH), registered with count.
REQ-025 LineStart during SETUP (Phase even, <12): STROBE cancelled, chip selects <=1, head retained and retried; no partial write.
REQ-026 LineStart during video slot: slot abandoned, chip selects <=1, no VidValid.
REQ-027 nRWE SHALL never change in a cycle where either chip select is low (write-then-read and read-then-write separated by one deselected cycle).
REQ-028 Throughput: up to six writes per 16 cycles; a push at cycle t is eligible for the first SETUP at or after t+1.

Reset
REQ-029 RST high SHALL immediately force: Phase=0, FIFO empty, WrFull=0, Overflow=0, RA=0, RDout=0, RDoe=0, nRCSH=nRCSL=nRWE=1, VidData=0, VidValid=0.
REQ-030 After RST falls, operation SHALL start at Phase 0 on first clock edge; mid-write reset abandons write, chip selects high asynchronously.

Verification
REQ-031 Single write: WrReq WrAddr=0x01234 WrData=0xBEEF both strobes low, Phase 3 -> Phase 4 RA=0x01234 RDout=0xBEEF nRWE=0; Phase 5 nRCSH=nRCSL=0 for one cycle.
REQ-032 Byte write: WrnUDS=1 WrnLDS=0 -> only nRCSL low during STROBE, nRCSH stays 1.
REQ-033 Video: FetchAddr=0x1F00, RDin=0xA5A5 -> Phase 12 RA=0x1F00 nRWE=1; Phase 13-14 both CS low; Phase 15 VidData=0xA5A5 VidValid=1.
REQ-034 Overflow: 5 WrReq in consecutive cycles starting Phase 12, depth 4 -> WrFull=1 after 4th, 5th dropped, Overflow=1; four writes issued Phase 1,3,5,7 in order.
REQ-035 LineStart at Phase 4 with FIFO entry -> no CS low at Phase 5; same entry written at next Phase 0/1.
REQ-036 RST asserted at Phase 1 of active write -> CS high without clock edge, FIFO empty, all outputs at reset values.
